// File: rtl/mii_rx_frame_checker.sv
`timescale 1ns/1ps
// MII receive frame checker: one-cycle forward path plus per-frame validation
// of preamble/SFD, CRC-32 residue, destination address and fixed length.
module mii_rx_frame_checker #(
  parameter logic [47:0] MAC_ADD       = 48'h0000_0000_0001,
  parameter bit          ACCEPT_BCAST  = 1'b1,
  parameter int unsigned FRAME_NIBBLES = 128,
  parameter int unsigned PRE_MIN       = 7,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             phy_rxclk,
  input  logic             rst_n,
  input  logic [3:0]       phy_rxd,
  input  logic             phy_rxen,
  input  logic             phy_rxer,
  output logic [3:0]       fwd_rxd,
  output logic             fwd_rxen,
  output logic             fwd_rxer,
  output logic             frame_done,
  output logic             frame_good,
  output logic             crc_err,
  output logic             da_err,
  output logic             len_err,
  output logic             rx_err,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] crc_err_cnt,
  output logic [CNT_W-1:0] da_err_cnt,
  output logic [CNT_W-1:0] len_err_cnt,
  output logic [CNT_W-1:0] rx_err_cnt
);

  localparam int unsigned       NIB_W       = 12;
  localparam logic [31:0]       CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0]       CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0]       CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [NIB_W-1:0]  DA_NIBBLES  = NIB_W'(12);
  localparam logic [NIB_W-1:0]  FRAME_LEN   = NIB_W'(FRAME_NIBBLES);
  localparam logic [3:0]        PRE_REQ     = 4'(PRE_MIN);
  // Padded to 16 nibbles so the DA lookup index never leaves the vector.
  localparam logic [63:0]       MAC_EXT     = {16'h0000, MAC_ADD};

  typedef enum logic [2:0] {IDLE, PRE, BODY, DROP_ERR, DROP_SILENT} state_t;

  state_t           state;
  logic [3:0]       pre_cnt;
  logic [NIB_W-1:0] nib_cnt;
  logic [31:0]      crc;
  logic             mac_miss;
  logic             bcast_miss;

  logic             rx_ok_c;
  logic             in_da_c;
  logic [3:0]       mac_nib_c;
  logic             verdict_c;
  logic             v_crc_c;
  logic             v_da_c;
  logic             v_len_c;
  logic             v_rx_c;
  logic             v_good_c;

  // Reflected CRC-32 advanced by one nibble, LSB first.
  function automatic logic [31:0] crc_nibble(input logic [31:0] c_in, input logic [3:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 4; i++) begin
      c = (c >> 1) ^ (((c[0] ^ d[i]) == 1'b1) ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Per-cycle decode and the verdict that would be issued this cycle.
  always_comb begin
    rx_ok_c   = phy_rxen & ~phy_rxer;
    in_da_c   = (nib_cnt < DA_NIBBLES);
    mac_nib_c = MAC_EXT[{nib_cnt[3:0], 2'b00} +: 4];
    verdict_c = ~phy_rxen & ((state == BODY) | (state == DROP_ERR));
    v_rx_c    = (state == DROP_ERR);
    v_crc_c   = (state == BODY) & (crc != CRC_RESIDUE);
    v_da_c    = (state == BODY) & ((mac_miss & (bcast_miss | ~ACCEPT_BCAST)) | in_da_c);
    v_len_c   = (state == BODY) & (nib_cnt != FRAME_LEN);
    v_good_c  = ~(v_crc_c | v_da_c | v_len_c | v_rx_c);
  end

  // Forward path: plain one-cycle delay of the PHY signals.
  always_ff @(posedge phy_rxclk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_rxd  <= 4'h0;
      fwd_rxen <= 1'b0;
      fwd_rxer <= 1'b0;
    end else begin
      fwd_rxd  <= phy_rxd;
      fwd_rxen <= phy_rxen;
      fwd_rxer <= phy_rxer;
    end
  end

  // Frame FSM with registered verdict, status flags and counters.
  always_ff @(posedge phy_rxclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pre_cnt     <= 4'h0;
      nib_cnt     <= '0;
      crc         <= 32'h0;
      mac_miss    <= 1'b0;
      bcast_miss  <= 1'b0;
      frame_done  <= 1'b0;
      frame_good  <= 1'b0;
      crc_err     <= 1'b0;
      da_err      <= 1'b0;
      len_err     <= 1'b0;
      rx_err      <= 1'b0;
      good_cnt    <= '0;
      crc_err_cnt <= '0;
      da_err_cnt  <= '0;
      len_err_cnt <= '0;
      rx_err_cnt  <= '0;
    end else begin
      frame_done <= verdict_c;
      if (verdict_c) begin
        frame_good <= v_good_c;
        crc_err    <= v_crc_c;
        da_err     <= v_da_c;
        len_err    <= v_len_c;
        rx_err     <= v_rx_c;
        if (v_good_c) good_cnt    <= sat_inc(good_cnt);
        if (v_crc_c)  crc_err_cnt <= sat_inc(crc_err_cnt);
        if (v_da_c)   da_err_cnt  <= sat_inc(da_err_cnt);
        if (v_len_c)  len_err_cnt <= sat_inc(len_err_cnt);
        if (v_rx_c)   rx_err_cnt  <= sat_inc(rx_err_cnt);
      end

      case (state)
        IDLE: begin
          if (phy_rxen) begin
            if (rx_ok_c && phy_rxd == 4'h5) begin
              state   <= PRE;
              pre_cnt <= 4'h1;
            end else begin
              state <= DROP_SILENT;
            end
          end
        end
        PRE: begin
          if (!rx_ok_c) begin
            state <= DROP_SILENT;
          end else if (phy_rxd == 4'h5) begin
            pre_cnt <= (pre_cnt == 4'hF) ? pre_cnt : pre_cnt + 4'h1;
          end else if (phy_rxd == 4'hD && pre_cnt >= PRE_REQ) begin
            state      <= BODY;
            nib_cnt    <= '0;
            mac_miss   <= 1'b0;
            bcast_miss <= 1'b0;
            crc        <= CRC_INIT;
          end else begin
            state <= DROP_SILENT;
          end
        end
        BODY: begin
          if (!phy_rxen) begin
            state <= IDLE;
          end else if (phy_rxer) begin
            state <= DROP_ERR;
          end else begin
            crc     <= crc_nibble(crc, phy_rxd);
            nib_cnt <= (&nib_cnt) ? nib_cnt : nib_cnt + NIB_W'(1);
            if (in_da_c) begin
              if (phy_rxd != mac_nib_c) mac_miss   <= 1'b1;
              if (phy_rxd != 4'hF)      bcast_miss <= 1'b1;
            end
          end
        end
        DROP_ERR, DROP_SILENT: begin
          if (!phy_rxen) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mii_rx_frame_checker.sv
`timescale 1ns/1ps
// Directed bench for mii_rx_frame_checker: table of frame vectors plus
// back-to-back, mid-frame reset and counter saturation sequences.
module tb_mii_rx_frame_checker;

  localparam logic [47:0] MAC = 48'h0000_0000_0001;
  localparam int          NV_MAX = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  phy_rxd = 4'h0;
  logic        phy_rxen = 1'b0;
  logic        phy_rxer = 1'b0;

  logic [3:0]  fwd_rxd;
  logic        fwd_rxen, fwd_rxer;
  logic        frame_done, frame_good, crc_err, da_err, len_err, rx_err;
  logic [15:0] good_cnt, crc_err_cnt, da_err_cnt, len_err_cnt, rx_err_cnt;

  logic [3:0]  s_fwd_rxd;
  logic        s_fwd_rxen, s_fwd_rxer;
  logic        s_frame_done, s_frame_good, s_crc_err, s_da_err, s_len_err, s_rx_err;
  logic [3:0]  s_good_cnt, s_crc_err_cnt, s_da_err_cnt, s_len_err_cnt, s_rx_err_cnt;

  always #5 clk = ~clk;

  mii_rx_frame_checker #(
    .MAC_ADD(MAC), .ACCEPT_BCAST(1'b1), .FRAME_NIBBLES(128), .PRE_MIN(7), .CNT_W(16)
  ) dut (
    .phy_rxclk(clk), .rst_n(rst_n), .phy_rxd(phy_rxd), .phy_rxen(phy_rxen), .phy_rxer(phy_rxer),
    .fwd_rxd(fwd_rxd), .fwd_rxen(fwd_rxen), .fwd_rxer(fwd_rxer),
    .frame_done(frame_done), .frame_good(frame_good), .crc_err(crc_err), .da_err(da_err),
    .len_err(len_err), .rx_err(rx_err), .good_cnt(good_cnt), .crc_err_cnt(crc_err_cnt),
    .da_err_cnt(da_err_cnt), .len_err_cnt(len_err_cnt), .rx_err_cnt(rx_err_cnt)
  );

  mii_rx_frame_checker #(
    .MAC_ADD(MAC), .ACCEPT_BCAST(1'b1), .FRAME_NIBBLES(128), .PRE_MIN(7), .CNT_W(4)
  ) dut4 (
    .phy_rxclk(clk), .rst_n(rst_n), .phy_rxd(phy_rxd), .phy_rxen(phy_rxen), .phy_rxer(phy_rxer),
    .fwd_rxd(s_fwd_rxd), .fwd_rxen(s_fwd_rxen), .fwd_rxer(s_fwd_rxer),
    .frame_done(s_frame_done), .frame_good(s_frame_good), .crc_err(s_crc_err), .da_err(s_da_err),
    .len_err(s_len_err), .rx_err(s_rx_err), .good_cnt(s_good_cnt), .crc_err_cnt(s_crc_err_cnt),
    .da_err_cnt(s_da_err_cnt), .len_err_cnt(s_len_err_cnt), .rx_err_cnt(s_rx_err_cnt)
  );

  typedef struct {
    string name;
    int    pre_len;
    int    da_mode;   // 0: MAC_ADD, 1: DA nibble 0 corrupted, 2: broadcast
    int    n_nib;
    int    flip_idx;  // body nibble XORed with 1 after the FCS is computed, -1 none
    int    err_idx;   // body nibble sent with phy_rxer high, -1 none
    bit    exp_done;
    bit    exp_good, exp_crc, exp_da, exp_len, exp_rx;
  } vec_t;

  vec_t       vecs [NV_MAX];
  int         nv = 0;
  logic [3:0] nib [0:255];
  int         nn = 0;

  int n_tests = 0, n_fail = 0;
  int fwd_bad = 0, done_seen = 0;
  logic [3:0] prev_d = 4'h0;
  logic prev_en = 1'b0, prev_er = 1'b0;
  int exp_good = 0, exp_crc = 0, exp_da = 0, exp_len = 0, exp_rx = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input int pre_len, input int da_mode, input int n_nib,
                     input int flip_idx, input int err_idx, input bit e_done, input bit e_good,
                     input bit e_crc, input bit e_da, input bit e_len, input bit e_rx);
    vecs[nv].name = nm;          vecs[nv].pre_len = pre_len;
    vecs[nv].da_mode = da_mode;  vecs[nv].n_nib = n_nib;
    vecs[nv].flip_idx = flip_idx; vecs[nv].err_idx = err_idx;
    vecs[nv].exp_done = e_done;  vecs[nv].exp_good = e_good;
    vecs[nv].exp_crc = e_crc;    vecs[nv].exp_da = e_da;
    vecs[nv].exp_len = e_len;    vecs[nv].exp_rx = e_rx;
    nv++;
  endtask

  // Build the frame body (DA..FCS) as nibbles, FCS computed bytewise.
  task automatic build(input int da_mode, input int n_nib, input int flip_idx);
    logic [7:0]  b;
    logic [31:0] c;
    int nb;
    nb = (n_nib - 8) / 2;
    c  = 32'hFFFF_FFFF;
    nn = 0;
    for (int j = 0; j < nb; j++) begin
      if (j < 6) begin
        b = (da_mode == 2) ? 8'hFF : MAC[8*j +: 8];
        if (da_mode == 1 && j == 0) b = b ^ 8'h01;
      end else if (j < 12) b = 8'(8'h10 + j);
      else if (j == 12) b = 8'h08;
      else if (j == 13) b = 8'h00;
      else b = 8'(j * 7 + 3);
      for (int i = 0; i < 8; i++) c = (c >> 1) ^ (((c[0] ^ b[i]) == 1'b1) ? 32'hEDB8_8320 : 32'h0);
      nib[nn] = b[3:0]; nib[nn+1] = b[7:4]; nn += 2;
    end
    c = ~c;
    for (int k = 0; k < 4; k++) begin
      b = c[8*k +: 8];
      nib[nn] = b[3:0]; nib[nn+1] = b[7:4]; nn += 2;
    end
    if (flip_idx >= 0) nib[flip_idx] = nib[flip_idx] ^ 4'h1;
  endtask

  // One MII cycle: check forward path and count verdict pulses, then drive.
  task automatic drive(input logic en, input logic er, input logic [3:0] d);
    @(negedge clk);
    if (fwd_rxd !== prev_d || fwd_rxen !== prev_en || fwd_rxer !== prev_er) fwd_bad++;
    if (frame_done === 1'b1) done_seen++;
    phy_rxen = en; phy_rxer = er; phy_rxd = d;
    prev_d = d; prev_en = en; prev_er = er;
  endtask

  task automatic send_body(input int pre_len, input int err_idx, input int n_send);
    for (int p = 0; p < pre_len; p++) drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < n_send; i++) drive(1'b1, (i == err_idx), nib[i]);
  endtask

  task automatic check_counters(input string nm);
    check({nm, "_good_cnt"}, 32'(good_cnt), exp_good);
    check({nm, "_crc_err_cnt"}, 32'(crc_err_cnt), exp_crc);
    check({nm, "_da_err_cnt"}, 32'(da_err_cnt), exp_da);
    check({nm, "_len_err_cnt"}, 32'(len_err_cnt), exp_len);
    check({nm, "_rx_err_cnt"}, 32'(rx_err_cnt), exp_rx);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //    name         pre da  len  flip err done good crc da len rx
    add("good",        15, 0, 128,  -1, -1, 1,   1,  0,  0, 0,  0);
    add("crc_flip",    15, 0, 128,  60, -1, 1,   0,  1,  0, 0,  0);
    add("da_nib0",     15, 1, 128,  -1, -1, 1,   0,  0,  1, 0,  0);
    add("bcast",       15, 2, 128,  -1, -1, 1,   1,  0,  0, 0,  0);
    add("long",        15, 0, 130,  -1, -1, 1,   0,  0,  0, 1,  0);
    add("short126",    15, 0, 126,  -1, -1, 1,   0,  0,  0, 1,  0);
    add("rxer40",      15, 0, 128,  -1, 40, 1,   0,  0,  0, 0,  1);
    add("pre5",         5, 0, 128,  -1, -1, 0,   0,  0,  0, 0,  0);
    add("pre6",         6, 0, 128,  -1, -1, 0,   0,  0,  0, 0,  0);
    add("pre7",         7, 0, 128,  -1, -1, 1,   1,  0,  0, 0,  0);
    add("tiny10",      15, 0,  10,  -1, -1, 1,   0,  0,  1, 1,  0);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_fwd_rxen", 32'(fwd_rxen), 0);
    rst_n = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 4'h0);
    check("post_rst_frame_good", 32'(frame_good), 0);
    check("post_rst_flags", 32'({crc_err, da_err, len_err, rx_err}), 0);
    check_counters("post_rst");

    // Table-driven frames.
    for (int t = 0; t < nv; t++) begin
      build(vecs[t].da_mode, vecs[t].n_nib, vecs[t].flip_idx);
      fwd_bad = 0; done_seen = 0;
      send_body(vecs[t].pre_len, vecs[t].err_idx, nn);
      drive(1'b0, 1'b0, 4'h0);
      check({vecs[t].name, "_no_early_done"}, done_seen, 0);
      @(negedge clk);
      check({vecs[t].name, "_done"}, 32'(frame_done), 32'(vecs[t].exp_done));
      if (vecs[t].exp_done) begin
        check({vecs[t].name, "_frame_good"}, 32'(frame_good), 32'(vecs[t].exp_good));
        check({vecs[t].name, "_crc_err"}, 32'(crc_err), 32'(vecs[t].exp_crc));
        check({vecs[t].name, "_da_err"}, 32'(da_err), 32'(vecs[t].exp_da));
        check({vecs[t].name, "_len_err"}, 32'(len_err), 32'(vecs[t].exp_len));
        check({vecs[t].name, "_rx_err"}, 32'(rx_err), 32'(vecs[t].exp_rx));
        if (vecs[t].exp_good) exp_good++;
        if (vecs[t].exp_crc)  exp_crc++;
        if (vecs[t].exp_da)   exp_da++;
        if (vecs[t].exp_len)  exp_len++;
        if (vecs[t].exp_rx)   exp_rx++;
      end
      check_counters(vecs[t].name);
      @(negedge clk);
      check({vecs[t].name, "_done_pulse"}, 32'(frame_done), 0);
      check({vecs[t].name, "_fwd_path"}, fwd_bad, 0);
    end

    // Back-to-back good frames separated by a single idle cycle.
    build(0, 128, -1);
    done_seen = 0; fwd_bad = 0;
    send_body(15, -1, nn);
    drive(1'b0, 1'b0, 4'h0);
    send_body(15, -1, nn);
    drive(1'b0, 1'b0, 4'h0);
    repeat (3) drive(1'b0, 1'b0, 4'h0);
    check("b2b_done_count", done_seen, 2);
    exp_good += 2;
    check("b2b_good_cnt", 32'(good_cnt), exp_good);
    check("b2b_frame_good", 32'(frame_good), 1);
    check("b2b_fwd_path", fwd_bad, 0);

    // Reset asserted in the middle of the body.
    send_body(15, -1, 30);
    @(negedge clk);
    rst_n = 1'b0;
    phy_rxen = 1'b0; phy_rxer = 1'b0; phy_rxd = 4'h0;
    prev_en = 1'b0; prev_er = 1'b0; prev_d = 4'h0;
    #1;
    check("midrst_fwd_rxen", 32'(fwd_rxen), 0);
    check("midrst_fwd_rxd", 32'(fwd_rxd), 0);
    check("midrst_frame_good", 32'(frame_good), 0);
    check("midrst_good_cnt", 32'(good_cnt), 0);
    check("midrst_rx_err_cnt", 32'(rx_err_cnt), 0);
    exp_good = 0; exp_crc = 0; exp_da = 0; exp_len = 0; exp_rx = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (6) drive(1'b0, 1'b0, 4'h0);
    check("midrst_no_verdict", done_seen, 0);
    check_counters("midrst");
    send_body(15, -1, nn);
    drive(1'b0, 1'b0, 4'h0);
    @(negedge clk);
    check("after_rst_done", 32'(frame_done), 1);
    check("after_rst_frame_good", 32'(frame_good), 1);
    exp_good++;
    check_counters("after_rst");

    // Counter saturation on the narrow-counter instance.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_good = 0;
    for (int f = 0; f < 19; f++) begin
      send_body(15, -1, nn);
      drive(1'b0, 1'b0, 4'h0);
      drive(1'b0, 1'b0, 4'h0);
      exp_good++;
    end
    repeat (2) drive(1'b0, 1'b0, 4'h0);
    check("sat_good_cnt_w4", 32'(s_good_cnt), 15);
    check("sat_good_cnt_w16", 32'(good_cnt), exp_good);
    check("sat_len_err_cnt_w4", 32'(s_len_err_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
